note_tone_gen: RTL and testbench



---
 rtl/piano_pkg.sv | 50 +++++
 rtl/note_sync_filter.sv | 87 ++++++++
 rtl/note_tone_gen.sv | 180 ++++++++++++++++++
 tb/tb_note_tone_gen.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// ---------------------------------------------------------------------------
// piano_pkg
//   Shared definitions for the note tone generator:
//     - 4-bit note codes (C5..C4 = 0..7, NONE = 8; 9..15 are also silent)
//     - half_period(code): 100 MHz half-period length in clock cycles for a
//       note code, 0 for any silent code
//     - tone_state_e: speaker FSM state encoding
//   Optional feature macro used by the top level: TONE_VOLUME_EN.
// ---------------------------------------------------------------------------
package piano_pkg;

    // Width of the raw half-period table entries (largest entry is 191110).
    localparam int HP_W = 18;

    localparam logic [3:0] NOTE_C5   = 4'd0;
    localparam logic [3:0] NOTE_B4   = 4'd1;
    localparam logic [3:0] NOTE_A4   = 4'd2;
    localparam logic [3:0] NOTE_G4   = 4'd3;
    localparam logic [3:0] NOTE_F4   = 4'd4;
    localparam logic [3:0] NOTE_E4   = 4'd5;
    localparam logic [3:0] NOTE_D4   = 4'd6;
    localparam logic [3:0] NOTE_C4   = 4'd7;
    localparam logic [3:0] NOTE_NONE = 4'd8;

    typedef enum logic [1:0] {
        ST_SILENT = 2'd0,
        ST_HIGH   = 2'd1,
        ST_LOW    = 2'd2
    } tone_state_e;

    // Codes 0..7 carry a pitch; bit 3 set means silence (8..15).
    function automatic logic note_is_pitch(input logic [3:0] code);
        return ~code[3];
    endfunction

    function automatic logic [HP_W-1:0] half_period(input logic [3:0] code);
        case (code)
            NOTE_C5: return 18'd95557;
            NOTE_B4: return 18'd101239;
            NOTE_A4: return 18'd113636;
            NOTE_G4: return 18'd127551;
            NOTE_F4: return 18'd143172;
            NOTE_E4: return 18'd151685;
            NOTE_D4: return 18'd170265;
            NOTE_C4: return 18'd191110;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/note_sync_filter.sv
// ---------------------------------------------------------------------------
// note_sync_filter
//   Brings the asynchronous 4-bit note code into the CLK domain and only
//   publishes a code once it has been stable for STABLE_CYCLES consecutive
//   synchronized samples. Short glitches on the sequencer side never reach
//   pending_o.
//
//   Ports:
//     CLK        in   system clock
//     RESET      in   asynchronous, active-high reset (all state -> NONE)
//     note_i     in   [3:0] note code, asynchronous to CLK
//     pending_o  out  [3:0] last code that passed the stability filter
//
//   Parameters:
//     SYNC_STAGES    synchronizer depth (keep >= 2)
//     STABLE_CYCLES  consecutive equal samples needed to accept a code
// ---------------------------------------------------------------------------
module note_sync_filter
    import piano_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] note_i,
    output logic [3:0] pending_o
);

    localparam int             RUN_W     = $clog2(STABLE_CYCLES + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);

    // Synchronizer chain; only the last stage is used downstream.
    logic [3:0] sync_q [SYNC_STAGES];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= NOTE_NONE;
            end
        end else begin
            sync_q[0] <= note_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    logic [3:0]       sync_note;
    logic [3:0]       cand_q;
    logic [RUN_W-1:0] run_q, run_d;
    logic [3:0]       pending_q, pending_d;

    assign sync_note = sync_q[SYNC_STAGES-1];

    // run_d counts how many consecutive cycles sync_note has held its value,
    // including the current sample, saturating at the acceptance limit.
    // The code is published on the same edge that the run reaches the limit.
    always_comb begin
        run_d     = run_q;
        pending_d = pending_q;
        if (sync_note != cand_q) begin
            run_d = RUN_ONE;
        end else if (run_q != RUN_LIMIT) begin
            run_d = run_q + RUN_ONE;
        end
        if (run_d == RUN_LIMIT) begin
            pending_d = sync_note;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cand_q    <= NOTE_NONE;
            run_q     <= '0;
            pending_q <= NOTE_NONE;
        end else begin
            cand_q    <= sync_note;
            run_q     <= run_d;
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/note_tone_gen.sv
// ---------------------------------------------------------------------------
// note_tone_gen
//   Square-wave speaker driver for the auto-play song sequencer. The note
//   code is synchronized and debounced (note_sync_filter), then a
//   SILENT/HIGH/LOW FSM generates the tone. Pitch is only re-evaluated when a
//   half period finishes, so pitch changes are phase continuous and no pulse
//   is ever shorter than the shorter of the two half periods involved.
//
//   Ports:
//     CLK       in   100 MHz system clock
//     RESET     in   asynchronous, active-high reset
//     note      in   [3:0] note code (0=C5 .. 7=C4, 8..15 silent), async
//     enable    in   synchronous mute, 0 forces silence on the next edge
//     volume    in   [2:0] PWM volume (only with TONE_VOLUME_EN defined)
//     speaker   out  square-wave drive
//     playing   out  high while a pitch is being generated
//     cur_note  out  [3:0] currently accepted code (8 after a silent code)
//
//   Parameters:
//     CNT_W          half-period counter width (must hold 191110)
//     SYNC_STAGES    note synchronizer depth, >= 2
//     STABLE_CYCLES  samples needed before a new note code is accepted
//     HP_SHIFT       right shift applied to every table entry; 0 gives the
//                    true pitches, larger values give proportionally
//                    shorter periods for fast simulation of long songs
//
//   Optional feature: define TONE_VOLUME_EN to add the volume port and gate
//   the speaker with an 8-bit free-running PWM carrier.
// ---------------------------------------------------------------------------
module note_tone_gen
    import piano_pkg::*;
#(
    parameter int CNT_W         = 18,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int HP_SHIFT      = 0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] note,
    input  logic       enable,
`ifdef TONE_VOLUME_EN
    input  logic [2:0] volume,
`endif
    output logic       speaker,
    output logic       playing,
    output logic [3:0] cur_note
);

    // ------------------------------------------------------------------
    // Note code synchronizer + stability filter
    // ------------------------------------------------------------------
    logic [3:0] pending;

    note_sync_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_sync_filter (
        .CLK       (CLK),
        .RESET     (RESET),
        .note_i    (note),
        .pending_o (pending)
    );

    // ------------------------------------------------------------------
    // Reload value for the pending code. The counter runs reload..0, so a
    // half period of N cycles loads N-1. For silent codes the value is
    // meaningless and never loaded.
    // ------------------------------------------------------------------
    logic             pend_valid;
    logic [HP_W-1:0]  pend_hp;
    logic [CNT_W-1:0] pend_reload;

    assign pend_valid  = note_is_pitch(pending);
    assign pend_hp     = half_period(pending);
    assign pend_reload = CNT_W'(pend_hp >> HP_SHIFT) - CNT_W'(1);

    // ------------------------------------------------------------------
    // Tone FSM
    // ------------------------------------------------------------------
    tone_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             speaker_q, speaker_d;
    logic [3:0]       cur_note_q, cur_note_d;
    logic             playing_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        speaker_d  = speaker_q;
        cur_note_d = cur_note_q;

        if (!enable) begin
            // Mute takes priority over any half-period boundary; the last
            // accepted note stays visible on cur_note.
            state_d   = ST_SILENT;
            count_d   = '0;
            speaker_d = 1'b0;
        end else begin
            case (state_q)
                ST_SILENT: begin
                    count_d   = '0;
                    speaker_d = 1'b0;
                    if (pend_valid) begin
                        state_d    = ST_HIGH;
                        count_d    = pend_reload;
                        cur_note_d = pending;
                        speaker_d  = 1'b1;
                    end
                end

                ST_HIGH, ST_LOW: begin
                    if (count_q != '0) begin
                        count_d = count_q - CNT_W'(1);
                    end else if (pend_valid) begin
                        // Boundary: flip level and pick up whatever code is
                        // pending now (same or new pitch, same reload path).
                        state_d    = (state_q == ST_HIGH) ? ST_LOW : ST_HIGH;
                        speaker_d  = (state_q == ST_LOW);
                        count_d    = pend_reload;
                        cur_note_d = pending;
                    end else begin
                        state_d    = ST_SILENT;
                        speaker_d  = 1'b0;
                        count_d    = '0;
                        cur_note_d = NOTE_NONE;
                    end
                end

                default: begin
                    state_d   = ST_SILENT;
                    count_d   = '0;
                    speaker_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_SILENT;
            count_q    <= '0;
            speaker_q  <= 1'b0;
            cur_note_q <= NOTE_NONE;
            playing_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            speaker_q  <= speaker_d;
            cur_note_q <= cur_note_d;
            // Registered from the next state so it lines up with state_q.
            playing_q  <= (state_d != ST_SILENT);
        end
    end

    assign playing  = playing_q;
    assign cur_note = cur_note_q;

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------
`ifdef TONE_VOLUME_EN
    // Free-running PWM carrier; the top three bits against volume give a
    // duty of volume/8 (0 = always off, 7 = 7/8 on).
    logic [7:0] carrier_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            carrier_q <= '0;
        end else begin
            carrier_q <= carrier_q + 8'd1;
        end
    end

    assign speaker = speaker_q & (carrier_q[7:5] < volume);
`else
    assign speaker = speaker_q;
`endif

endmodule

// File: tb/tb_note_tone_gen.sv
// ---------------------------------------------------------------------------
// tb_note_tone_gen
//   Self-checking bench for note_tone_gen. Expected half-period lengths come
//   from the published note table (scaled by the same shift the DUT is built
//   with) and expected latencies from the synchronizer/filter depths; the
//   bench measures edge-to-edge intervals on the speaker output and compares.
//   Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_note_tone_gen;

    localparam int SHIFT   = 6;
    localparam int SYNC_N  = 2;
    localparam int STAB_N  = 4;
    localparam int LATENCY = SYNC_N + STAB_N + 1;
    localparam int LIMIT   = 4000;

    localparam int HP_TABLE [8] = '{95557, 101239, 113636, 127551,
                                    143172, 151685, 170265, 191110};

    logic       CLK;
    logic       RESET;
    logic [3:0] note;
    logic       enable;
    logic       speaker;
    logic       playing;
    logic [3:0] cur_note;
`ifdef TONE_VOLUME_EN
    logic [2:0] volume;
`endif

    int errors = 0;
    int checks = 0;
    int last_note = 8;

    note_tone_gen #(
        .CNT_W         (18),
        .SYNC_STAGES   (SYNC_N),
        .STABLE_CYCLES (STAB_N),
        .HP_SHIFT      (SHIFT)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .note     (note),
        .enable   (enable),
`ifdef TONE_VOLUME_EN
        .volume   (volume),
`endif
        .speaker  (speaker),
        .playing  (playing),
        .cur_note (cur_note)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int exp_hp(input int code);
        return (code >= 0 && code < 8) ? (HP_TABLE[code] >> SHIFT) : 0;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic cycles(input int k);
        repeat (k) @(negedge CLK);
    endtask

    // Cycles until speaker differs from its current level; -1 on timeout.
    task automatic wait_toggle(output int n, input int limit);
        logic prev;
        prev = speaker;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (speaker === prev && n < limit);
        if (speaker === prev) n = -1;
    endtask

    // Cycles until speaker is high; -1 on timeout.
    task automatic wait_high(output int n, input int limit);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (speaker !== 1'b1 && n < limit);
        if (speaker !== 1'b1) n = -1;
    endtask

    // Mute, then restart with a pre-settled code: the tone must stop on the
    // next edge and start on the first edge after enable returns.
    task automatic restart(input int code);
        enable = 1'b0;
        @(negedge CLK);
        check("mute_speaker", speaker, 0);
        check("mute_playing", playing, 0);
        check("mute_cur_hold", cur_note, last_note);
        note = code[3:0];
        cycles(10);
        enable = 1'b1;
        @(negedge CLK);
        check("start_speaker", speaker, 1);
        check("start_cur", cur_note, code);
        last_note = code;
    endtask

    // Start note a, switch to b r cycles into the first high half period.
    task automatic pitch_change(input int a, input int b, input int r);
        int m;
        restart(a);
        cycles(r);
        note = b[3:0];
        wait_toggle(m, LIMIT);
        check("chg_first_half", (m < 0) ? -1 : r + m, exp_hp(a));
        check("chg_cur", cur_note, b);
        wait_toggle(m, LIMIT);
        check("chg_low_half", m, exp_hp(b));
        wait_toggle(m, LIMIT);
        check("chg_high_half", m, exp_hp(b));
        last_note = b;
    endtask

    initial begin
        int n, m, a, b, r, g, hi;

        RESET  = 1'b1;
        note   = 4'd8;
        enable = 1'b0;
`ifdef TONE_VOLUME_EN
        volume = 3'd0;
`endif
        cycles(3);
        check("rst_speaker", speaker, 0);
        check("rst_playing", playing, 0);
        check("rst_cur", cur_note, 8);
        RESET = 1'b0;

        // Silent code with enable high: nothing happens.
        enable = 1'b1;
        hi = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLK);
            if (speaker !== 1'b0) hi++;
            if (playing !== 1'b0) hi++;
        end
        check("idle_active", hi, 0);
        check("idle_cur", cur_note, 8);

`ifdef TONE_VOLUME_EN
        // Volume 0: tone runs but the output stays low.
        note = 4'd2;
        cycles(20);
        check("vol0_playing", playing, 1);
        check("vol0_cur", cur_note, 2);
        hi = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK);
            if (speaker) hi++;
        end
        check("vol0_highs", hi, 0);
        // Inside the first high half period any 256-cycle window sees
        // exactly volume*32 gated-on cycles.
        volume = 3'd4;
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            if (speaker) hi++;
        end
        check("vol4_duty", hi, 128);
        volume = 3'd7;
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge CLK);
            if (speaker) hi++;
        end
        check("vol7_duty", hi, 224);
        #2 RESET = 1'b1;
        #1;
        check("async_rst_speaker", speaker, 0);
        check("async_rst_playing", playing, 0);
        check("async_rst_cur", cur_note, 8);
        @(negedge CLK);
        RESET = 1'b0;
`else
        // A4 from silence: latency, then steady half periods.
        note = 4'd2;
        wait_high(n, 50);
        check("a4_latency", n, LATENCY);
        check("a4_playing", playing, 1);
        check("a4_cur", cur_note, 2);
        last_note = 2;
        wait_toggle(n, LIMIT);
        check("a4_high", n, exp_hp(2));
        wait_toggle(n, LIMIT);
        check("a4_low", n, exp_hp(2));
        wait_toggle(n, LIMIT);
        check("a4_high2", n, exp_hp(2));

        // C4 -> C5 mid-high, then random pitch pairs and switch points.
        pitch_change(7, 0, 1000);
        for (int k = 0; k < 3; k++) begin
            a = $urandom_range(7, 0);
            b = $urandom_range(7, 0);
            r = $urandom_range(exp_hp(a) - 20, 10);
            pitch_change(a, b, r);
        end

        // Short glitch while playing G4 must be ignored.
        restart(3);
        cycles(100);
        g = $urandom_range(STAB_N - 1, 1);
        note = 4'd5;
        cycles(g);
        note = 4'd3;
        wait_toggle(m, LIMIT);
        check("glitch_high", (m < 0) ? -1 : 100 + g + m, exp_hp(3));
        check("glitch_cur", cur_note, 3);
        wait_toggle(m, LIMIT);
        check("glitch_low", m, exp_hp(3));

        // Mute and reassert on D4: first high is a full D4 half period.
        restart(6);
        check("d4_playing", playing, 1);
        wait_toggle(m, LIMIT);
        check("d4_first_high", m, exp_hp(6));

        // Reset asserted mid-low clears outputs without waiting for a clock.
        cycles(50);
        #2 RESET = 1'b1;
        #1;
        check("async_rst_speaker", speaker, 0);
        check("async_rst_playing", playing, 0);
        check("async_rst_cur", cur_note, 8);
        @(negedge CLK);
        RESET = 1'b0;
        wait_high(n, 50);
        check("post_rst_latency", n, LATENCY);
        last_note = 6;

        // Silent code takes effect at the end of the current half period.
        cycles(10);
        note = 4'd8;
        wait_toggle(m, LIMIT);
        check("silence_boundary", (m < 0) ? -1 : 10 + m, exp_hp(6));
        check("silence_playing", playing, 0);
        check("silence_cur", cur_note, 8);
        hi = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (speaker !== 1'b0) hi++;
        end
        check("silence_stays", hi, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
